// File: rtl/qos_router_if.sv
// Bus bundle for qos_router_param: input write port, per-channel read ports,
// pop-counter readout, threshold programming and FSM status.
interface qos_router_if #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 5,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic                     init;
  logic [ADDR_W:0]          umbralHigh;
  logic [ADDR_W:0]          umbralLow;
  logic [DATA_W-1:0]        data_in;
  logic                     push;
  logic                     in_full;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        almost_full;
  logic [NUM_CH-1:0]        almost_empty;
  logic                     req;
  logic [CH_W-1:0]          idx;
  logic [CNT_W-1:0]         data;
  logic                     valid;
  logic [2:0]               state_out;
  logic                     idle_out;
  logic                     active_out;
  logic                     error_out;

  modport slave (
    input  init, umbralHigh, umbralLow, data_in, push, pop, req, idx,
    output in_full, data_out, empty, almost_full, almost_empty,
           data, valid, state_out, idle_out, active_out, error_out
  );

  modport master (
    output init, umbralHigh, umbralLow, data_in, push, pop, req, idx,
    input  in_full, data_out, empty, almost_full, almost_empty,
           data, valid, state_out, idle_out, active_out, error_out
  );
endinterface

// File: rtl/qos_router_param.sv
// Generic FIFO: write visible at head next cycle; read data is the combinational head.
// No internal protection: the caller never writes when full nor reads when empty.
module qos_router_fifo #(
  parameter int W      = 12,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_dat,
  input  logic            rd_en,
  output logic [W-1:0]    rd_dat,
  output logic [ADDR_W:0] occ
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0]      mem_q [DEPTH];
  logic [W-1:0]      mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign occ    = occ_q;
endmodule

// QoS router: input FIFO -> one of NUM_CH channel FIFOs by class field; push->head 1 cycle,
// earliest channel visibility 2 cycles, pop->data_out 1 cycle; head-of-line stall on almost_full.
module qos_router_param #(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 4,
  parameter int CH_LSB   = 10,
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 5,
  parameter int HIGH_DEF = 6,
  parameter int LOW_DEF  = 1
) (
  input logic        clk,
  input logic        reset,
  qos_router_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [ADDR_W:0] occ_t;
  localparam occ_t DEPTH_OCC = occ_t'(DEPTH);
  localparam occ_t HIGH_RST  = occ_t'(HIGH_DEF);
  localparam occ_t LOW_RST   = occ_t'(LOW_DEF);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  occ_t                           high_q, high_d, low_q, low_d, hi_clamp;
  logic [NUM_CH-1:0][DATA_W-1:0]  dout_q, dout_d, ch_head;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]               rd_q, rd_d;
  logic                           vld_q, vld_d;

  logic [DATA_W-1:0] in_head;
  occ_t              in_occ;
  occ_t              ch_occ [NUM_CH];
  logic [NUM_CH-1:0] empty_v, afull_v, aempty_v, pop_ok, ch_wr;
  logic              in_full_v, op_en, push_ok, xfer, access_err, busy;
  logic [CH_W-1:0]   head_ch;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty_v[i]  = (ch_occ[i] == '0);
      afull_v[i]  = (ch_occ[i] >= high_q);
      aempty_v[i] = (ch_occ[i] <= low_q);
    end
  end

  assign in_full_v  = (in_occ == DEPTH_OCC);
  assign op_en      = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign push_ok    = op_en && bus.push && !in_full_v;
  assign pop_ok     = bus.pop & ~empty_v & {NUM_CH{op_en}};
  assign head_ch    = in_head[CH_LSB +: CH_W];
  assign xfer       = op_en && (in_occ != '0) && !afull_v[head_ch];
  assign access_err = (bus.push && in_full_v) || (|(bus.pop & empty_v));
  assign busy       = (in_occ != '0) || !(&empty_v);
  assign hi_clamp   = (bus.umbralHigh > DEPTH_OCC) ? DEPTH_OCC : bus.umbralHigh;

  always_comb begin
    ch_wr = '0;
    if (xfer) begin
      ch_wr[head_ch] = 1'b1;
    end
  end

  qos_router_fifo #(.W(DATA_W), .ADDR_W(ADDR_W)) u_in_fifo (
    .clk(clk), .reset(reset),
    .wr_en(push_ok), .wr_dat(bus.data_in),
    .rd_en(xfer), .rd_dat(in_head), .occ(in_occ)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    qos_router_fifo #(.W(DATA_W), .ADDR_W(ADDR_W)) u_ch_fifo (
      .clk(clk), .reset(reset),
      .wr_en(ch_wr[g]), .wr_dat(in_head),
      .rd_en(pop_ok[g]), .rd_dat(ch_head[g]), .occ(ch_occ[g])
    );
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        // An inverted or degenerate window falls back to the defaults as a pair.
        if (bus.umbralLow >= hi_clamp) begin
          high_d = HIGH_RST;
          low_d  = LOW_RST;
        end else begin
          high_d = hi_clamp;
          low_d  = bus.umbralLow;
        end
        if (!bus.init) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.init)                 state_d = S_INIT;
        else if (busy || bus.push)    state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.init)                 state_d = S_INIT;
        else if (!busy && !bus.push)  state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
    if ((state_q != S_RESET) && access_err) begin
      state_d = S_ERROR;
    end
  end

  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    vld_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop_ok[i]) begin
        dout_d[i] = ch_head[i];
        cnt_d[i]  = cnt_q[i] + 1'b1;
      end
    end
    if (op_en && bus.req) begin
      rd_d  = cnt_q[bus.idx];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      high_q  <= HIGH_RST;
      low_q   <= LOW_RST;
      dout_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_full      = in_full_v;
  assign bus.data_out     = dout_q;
  assign bus.empty        = empty_v;
  assign bus.almost_full  = afull_v;
  assign bus.almost_empty = aempty_v;
  assign bus.data         = rd_q;
  assign bus.valid        = vld_q;
  assign bus.state_out    = state_q;
  assign bus.idle_out     = (state_q == S_IDLE);
  assign bus.active_out   = (state_q == S_ACTIVE);
  assign bus.error_out    = (state_q == S_ERROR);
endmodule

// File: tb/tb_qos_router_param.sv
// Bench for qos_router_param: per-channel scoreboard queues fed at push time and
// drained on pop, vector tables for routing, counter reads and threshold programming.
module tb_qos_router_param;
  localparam int DW = 12;
  localparam int NC = 4;
  localparam int AW = 3;
  localparam int CW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [DW-1:0] exp_q [NC][$];
  logic [DW-1:0] last_dout [NC];
  int            exp_cnt [NC];

  typedef struct { logic [DW-1:0] word; int ch; } push_vec_t;
  typedef struct { int idx; int cnt; } rd_vec_t;
  typedef struct { int hi; int lo; int eff_hi; int eff_lo; } thr_vec_t;

  push_vec_t push_tbl [5];
  rd_vec_t   rd_tbl   [4];
  thr_vec_t  thr_tbl  [5];

  always #5 clk = ~clk;

  qos_router_if #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .CNT_W(CW)) bus ();

  qos_router_param #(
    .DATA_W(DW), .NUM_CH(NC), .CH_LSB(10), .ADDR_W(AW), .CNT_W(CW),
    .HIGH_DEF(6), .LOW_DEF(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      exp_q[i].delete();
      last_dout[i] = '0;
      exp_cnt[i]   = 0;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input int ch);
    bus.data_in = w;
    bus.push    = 1'b1;
    exp_q[ch].push_back(w);
    tick();
    bus.push = 1'b0;
  endtask

  task automatic pop_mask(input logic [NC-1:0] m);
    bus.pop = m;
    for (int i = 0; i < NC; i++) begin
      if (m[i]) begin
        last_dout[i] = exp_q[i].pop_front();
        exp_cnt[i]   = (exp_cnt[i] + 1) % (1 << CW);
      end
    end
    tick();
    bus.pop = '0;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("dout_ch%0d", i), bus.data_out[i*DW +: DW], last_dout[i]);
    end
  endtask

  task automatic drain(input int ch);
    while (exp_q[ch].size() != 0) begin
      wait_cycles(2);
      pop_mask(NC'(1) << ch);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_out"}, bus.data_out, '0);
    chk({tag, "_data"}, bus.data, '0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_in_full"}, bus.in_full, 0);
    chk({tag, "_empty"}, bus.empty, 4'hF);
    chk({tag, "_afull"}, bus.almost_full, 4'h0);
    chk({tag, "_aempty"}, bus.almost_empty, 4'hF);
    chk({tag, "_state"}, bus.state_out, 0);
    chk({tag, "_error"}, bus.error_out, 0);
  endtask

  task automatic apply_init(input int hi, input int lo);
    bus.init       = 1'b1;
    bus.umbralHigh = 4'(hi);
    bus.umbralLow  = 4'(lo);
    tick();
    chk("init_state", bus.state_out, 1);
    tick();
    bus.init = 1'b0;
    tick();
    chk("init_to_idle", bus.state_out, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want $finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NC-1:0] m;
    int occ;

    push_tbl[0] = '{12'h37D, 0};
    push_tbl[1] = '{12'hF04, 3};
    push_tbl[2] = '{12'hE95, 3};
    push_tbl[3] = '{12'hAAE, 2};
    push_tbl[4] = '{12'hB5A, 2};
    rd_tbl[0]   = '{0, 1};
    rd_tbl[1]   = '{1, 0};
    rd_tbl[2]   = '{2, 2};
    rd_tbl[3]   = '{3, 2};
    thr_tbl[0]  = '{6, 1, 6, 1};
    thr_tbl[1]  = '{15, 2, 8, 2};
    thr_tbl[2]  = '{3, 5, 6, 1};
    thr_tbl[3]  = '{4, 4, 6, 1};
    thr_tbl[4]  = '{2, 0, 2, 0};

    bus.init       = 1'b0;
    bus.umbralHigh = 4'd6;
    bus.umbralLow  = 4'd1;
    bus.data_in    = '0;
    bus.push       = 1'b0;
    bus.pop        = '0;
    bus.req        = 1'b0;
    bus.idx        = '0;
    model_reset();

    reset = 1'b1;
    wait_cycles(3);
    check_reset_vals("rst");

    bus.init = 1'b1;
    reset    = 1'b0;
    tick();
    chk("boot_init", bus.state_out, 1);
    tick();
    bus.init = 1'b0;
    tick();
    chk("boot_idle", bus.state_out, 2);
    chk("boot_idle_out", bus.idle_out, 1);
    chk("boot_empty", bus.empty, 4'hF);

    foreach (push_tbl[k]) push_word(push_tbl[k].word, push_tbl[k].ch);
    wait_cycles(4);
    chk("route_state", bus.state_out, 3);
    chk("route_active_out", bus.active_out, 1);
    chk("route_empty", bus.empty, 4'b0010);
    chk("route_aempty", bus.almost_empty, 4'b0011);

    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NC; i++) m[i] = (exp_q[i].size() != 0);
      pop_mask(m);
    end
    chk("drain_idle", bus.state_out, 2);

    foreach (rd_tbl[k]) begin
      bus.req = 1'b1;
      bus.idx = 2'(rd_tbl[k].idx);
      tick();
      bus.req = 1'b0;
      chk($sformatf("cnt_valid%0d", k), bus.valid, 1);
      chk($sformatf("cnt_rd%0d", k), bus.data, rd_tbl[k].cnt);
    end
    tick();
    chk("cnt_valid_drop", bus.valid, 0);
    chk("cnt_data_hold", bus.data, 2);

    foreach (thr_tbl[r]) begin
      apply_init(thr_tbl[r].hi, thr_tbl[r].lo);
      for (int n = 1; n <= 8; n++) begin
        push_word(12'h800 | 12'(n), 2);
        wait_cycles(2);
        occ = (n < thr_tbl[r].eff_hi) ? n : thr_tbl[r].eff_hi;
        chk($sformatf("thr%0d_af_n%0d", r, n), bus.almost_full[2], occ >= thr_tbl[r].eff_hi);
        chk($sformatf("thr%0d_ae_n%0d", r, n), bus.almost_empty[2], occ <= thr_tbl[r].eff_lo);
      end
      drain(2);
      wait_cycles(2);
      chk($sformatf("thr%0d_idle", r), bus.state_out, 2);
    end

    // Head-of-line blocking on ch1 with a 2-word high threshold.
    apply_init(2, 1);
    for (int k = 0; k < 5; k++) push_word(12'h401 + 12'(k), 1);
    wait_cycles(4);
    chk("hol_afull", bus.almost_full[1], 1);
    chk("hol_nonempty", bus.empty[1], 0);
    chk("hol_in_not_full", bus.in_full, 0);
    pop_mask(4'b0010);
    wait_cycles(3);
    chk("hol_refill", bus.almost_full[1], 1);
    for (int k = 0; k < 6; k++) begin
      push_word(12'h406 + 12'(k), 1);
      chk($sformatf("fill_in_full%0d", k), bus.in_full, k == 5);
    end

    bus.data_in = 12'h40C;
    bus.push    = 1'b1;
    tick();
    bus.push = 1'b0;
    chk("ovf_error", bus.error_out, 1);
    chk("ovf_state", bus.state_out, 4);
    wait_cycles(3);
    chk("err_sticky", bus.error_out, 1);
    bus.pop = 4'b0010;
    tick();
    bus.pop = '0;
    chk("err_pop_ignored", bus.data_out[DW +: DW], last_dout[1]);
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    chk("err_req_ignored", bus.valid, 0);
    chk("err_still", bus.state_out, 4);

    reset = 1'b1;
    tick();
    check_reset_vals("mid_rst");
    model_reset();

    bus.init       = 1'b1;
    bus.umbralHigh = 4'd3;
    bus.umbralLow  = 4'd5;
    reset          = 1'b0;
    tick();
    chk("dflt_init", bus.state_out, 1);
    tick();
    bus.init = 1'b0;
    tick();
    chk("dflt_idle", bus.state_out, 2);
    for (int k = 0; k < 3; k++) push_word(12'h410 + 12'(k), 1);
    wait_cycles(3);
    chk("dflt_af3", bus.almost_full[1], 0);
    chk("dflt_ae3", bus.almost_empty[1], 0);
    for (int k = 3; k < 6; k++) push_word(12'h410 + 12'(k), 1);
    wait_cycles(3);
    chk("dflt_af6", bus.almost_full[1], 1);
    drain(1);
    wait_cycles(2);
    chk("dflt_back_idle", bus.state_out, 2);
    bus.pop = 4'b0001;
    tick();
    bus.pop = '0;
    chk("underflow_error", bus.error_out, 1);
    chk("underflow_state", bus.state_out, 4);
    chk("underflow_dout0", bus.data_out[0 +: DW], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
